mips_data_mem_unit: RTL and testbench
=====================================

Name: mips_data_mem_unit

Overview:
- Parametrised successor to the single-cycle data memory: a byte-addressed, word-organised RAM with a registered (block-RAM) read port and a second read-only instruction-fetch port.
- Supports the MIPS load/store widths BYTE, HALFWORD, WORD, WORDLEFT (lwl/swl) and WORDRIGHT (lwr/swr), with signed/unsigned loads and alignment/range error reporting.
- Clears all RAM contents after reset using a sweep state machine.
- Sits between the execute/memory pipeline stage and the fetch stage.

Parameters:
- DEPTH_WORDS, 16384: number of 32-bit words; must be a power of 2.
- ADDR_W, 32: width of the byte-address ports.
- CLEAR_ON_RESET, 1: 1 = zero-fill sweep after reset; 0 = go straight to READY, contents undefined.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  data request present this cycle
- req_ready  out  1  unit accepts data requests
- write_mode  in  3  MemoryModes: NONE/BYTE/HALFWORD/WORD/WORDLEFT/WORDRIGHT
- read_mode  in  3  MemoryModes; a request with both modes non-NONE is illegal and is flagged as an error
- unsigned_load  in  1  1 = zero-extend BYTE/HALFWORD loads
- address  in  ADDR_W  data byte address
- data  in  32  store data (rt)
- rt_data  in  32  current rt value, merged into the result by lwl/lwr
- data_output  out  32  load result
- resp_valid  out  1  data_output valid; one-cycle pulse
- err  out  1  pulse with resp_valid; misaligned, out-of-range or illegal request
- pc_address  in  ADDR_W  fetch byte address; bits [1:0] are ignored
- pc_valid  in  1  fetch request
- pc_data_output  out  32  fetched word
- pc_resp_valid  out  1  fetch data valid

Behaviour:
- Reset (asynchronous): state=CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0). req_ready=0, resp_valid=0, err=0, data_output=0, pc_data_output=0, pc_resp_valid=0, clear counter=0.
- CLEAR state: writes 0 to word[counter] each cycle, then counter+1. After word DEPTH_WORDS-1 is written, go to READY on the next edge; req_ready=1 in READY only.
  - Requests and fetches during CLEAR are ignored; no response is produced.
  - rst asserted mid-sweep restarts the sweep at counter 0.
- Acceptance: a request is accepted when req_valid && req_ready. Back-to-back acceptance is allowed every cycle.
- Word index: address[log2(DEPTH_WORDS)+1:2]. Byte offset k = address[1:0]. Little-endian: byte k occupies bits [8k+7:8k].
- Out of range: any address bit above log2(DEPTH_WORDS)+1 set → err, no write.
- Misaligned: HALFWORD with k odd, or WORD with k≠0 → err, no write (see optional feature).
- Stores: memory is written at the accepting edge using per-byte enables. Every store also produces resp_valid=1 one cycle later, with data_output=0 and err as computed.
  - BYTE: data[7:0] → byte k.
  - HALFWORD: data[15:0] → bytes k+1..k.
  - WORD: all four bytes.
  - WORDLEFT (swl): data[31:32-8(k+1)] → bytes k..0.
  - WORDRIGHT (swr): data[8(4-k)-1:0] → bytes 3..k.
- Loads: latency 1 cycle. resp_valid and data_output are registered and appear the cycle after acceptance.
  - BYTE/HALFWORD: selected bytes, sign- or zero-extended per unsigned_load.
  - WORD: full word.
  - WORDLEFT (lwl): bytes k..0 → result top 8(k+1) bits; remaining low bits from rt_data.
  - WORDRIGHT (lwr): bytes 3..k → result low 8(4-k) bits; remaining upper bits from rt_data.
  - On err, data_output=0.
- Forwarding: a load accepted the cycle after a store to the same word returns the post-store word.
- Simultaneous data store and fetch of the same word: the fetch returns the pre-store word.
- Fetch port: pc_valid in READY → pc_data_output = word[pc index] and pc_resp_valid=1 the next cycle. Fetch out-of-range addresses wrap modulo the depth.
- read_mode=NONE with write_mode=NONE: accepted as a no-op; resp_valid=1 next cycle, data_output=0, err=0.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: misaligned HALFWORD/WORD accesses raise err and are suppressed, as described above.
- Undefined: misaligned accesses are silently aligned down (k cleared for WORD, k[0] cleared for HALFWORD) and complete normally with err=0.

Test Plan:
- Reset, then count cycles → req_ready rises after exactly DEPTH_WORDS+1 edges (CLEAR_ON_RESET=1); a WORD read of any address → 0. Pulse rst mid-sweep → count restarts from 0.
- WORD store 0x22345678 @65532, then WORD load @65532 the next cycle → resp_valid one cycle later, 0x22345678 (exercises forwarding).
- BYTE stores 0xB2@65530, 0xD4@65528, 0xA1@65531, 0xC3@65529; WORD load @65528 → 0xA1B2C3D4. Signed BYTE load @65531 → 0xFFFFFFA1; unsigned → 0x000000A1.
- Zeroed word @65528. swl 0x12345678 at k=0,1,2 (clearing the word between each) → lw gives 0x12, 0x1234, 0x123456. lwl k=1 with rt_data=0xAAAAAAAA on word 0x00001234 → 0x1234AAAA.
- swr 0x12345678 @65530 on a zeroed word → lw 0x56780000. lwr @65530 with rt_data=0xFFFFFFFF → 0xFFFF5678.
- HALFWORD store @65529 → err=1 and memory unchanged (macro defined); macro undefined → bytes 65528–65529 written, err=0. Address 0x00100000 → err=1. Fetch @65528 concurrent with a WORD store there → old value returned.

Source files
------------

// File: rtl/mips_data_mem_unit.sv
// ---------------------------------------------------------------------------
// mips_data_mem_unit
//
// Byte-addressed, word-organised data RAM for the MIPS pipeline. It has a
// registered (block-RAM style) data read/write port and a second read-only
// instruction-fetch port. It supports MIPS load/store widths BYTE, HALFWORD,
// WORD, WORDLEFT (lwl/swl) and WORDRIGHT (lwr/swr), with signed/unsigned loads
// and error reporting. After reset, a sweep state machine zero-fills the RAM.
//
// Parameters:
//   DEPTH_WORDS    number of 32-bit words (power of 2)
//   ADDR_W         width of the byte-address ports
//   CLEAR_ON_RESET 1 = zero-fill sweep after reset, 0 = ready immediately
//
// Build option:
//   MEM_MISALIGN_TRAP_EN  when defined, a misaligned HALFWORD/WORD access
//                         raises err and is suppressed. When undefined, the
//                         address is aligned down and the access completes.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/ready    data request handshake (ready only in READY)
//   write_mode         store width (0 = NONE)
//   read_mode          load width (0 = NONE); both non-NONE is illegal
//   unsigned_load      zero-extend BYTE/HALFWORD loads
//   address            data byte address
//   data               store data
//   rt_data            rt value merged into the result by lwl/lwr
//   data_output        load result, valid while resp_valid is high
//   resp_valid, err    one-cycle response pulse and its error flag
//   pc_address         fetch byte address (bits [1:0] ignored)
//   pc_valid           fetch request
//   pc_data_output     fetched word, valid while pc_resp_valid is high
//   pc_resp_valid      fetch response pulse
// ---------------------------------------------------------------------------
module mips_data_mem_unit #(
  parameter int DEPTH_WORDS    = 16384,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        write_mode,
  input  logic [2:0]        read_mode,
  input  logic              unsigned_load,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data,
  input  logic [31:0]       rt_data,
  output logic [31:0]       data_output,
  output logic              resp_valid,
  output logic              err,
  input  logic [ADDR_W-1:0] pc_address,
  input  logic              pc_valid,
  output logic [31:0]       pc_data_output,
  output logic              pc_resp_valid
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] MODE_NONE      = 3'd0;
  localparam logic [2:0] MODE_BYTE      = 3'd1;
  localparam logic [2:0] MODE_HALFWORD  = 3'd2;
  localparam logic [2:0] MODE_WORD      = 3'd3;
  localparam logic [2:0] MODE_WORDLEFT  = 3'd4;
  localparam logic [2:0] MODE_WORDRIGHT = 3'd5;

  // CLEAR_DONE gives one extra settle cycle after the last word is zeroed.
  typedef enum logic [1:0] {CLEAR, CLEAR_DONE, READY} memState_t;

  localparam memState_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  memState_t        state, nextState;
  logic [IDX_W-1:0] clearCount;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic [IDX_W-1:0] wordIdx;
  logic [1:0]       byteOff;
  logic             outOfRange;
  logic             isStore, isLoad, illegal, misaligned, reqErr;
  logic [2:0]       accessMode;
  logic [1:0]       effK;

  logic [3:0]       storeBe;
  logic [31:0]      storeData;

  logic             memWe;
  logic [3:0]       memBe;
  logic [IDX_W-1:0] memIdx;
  logic [31:0]      memWd;

  logic [31:0]      rdWord, pcWord;
  logic             respQ, errQ, unsignedQ, pcRespQ;
  logic [2:0]       loadModeQ;
  logic [1:0]       kQ;
  logic [31:0]      rtQ;
  logic [31:0]      shifted;

  logic             pcRead;
  logic [IDX_W-1:0] pcIdx;
  logic             unusedPcBits;

  assign req_ready  = (state == READY);
  assign accept     = req_valid && req_ready;
  assign wordIdx    = address[IDX_W+1:2];
  assign byteOff    = address[1:0];
  assign outOfRange = |(address >> (IDX_W + 2));

  // Fetch addresses wrap modulo the depth, so only the index bits matter.
  assign pcIdx        = pc_address[IDX_W+1:2];
  assign pcRead       = pc_valid && (state == READY);
  assign unusedPcBits = ^pc_address;

  // Sweep state register and clear counter; a reset mid-sweep restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_STATE;
      clearCount <= '0;
    end else begin
      state <= nextState;
      if (state == CLEAR) clearCount <= clearCount + 1'b1;
    end
  end

  // Next-state logic: sweep every word, settle one cycle, then serve requests.
  always_comb begin
    nextState = state;
    case (state)
      CLEAR:      if (clearCount == IDX_W'(DEPTH_WORDS - 1)) nextState = CLEAR_DONE;
      CLEAR_DONE: nextState = READY;
      READY:      nextState = READY;
      default:    nextState = RESET_STATE;
    endcase
  end

  // Request decode: error conditions and the effective byte offset.
  always_comb begin
    isStore    = (write_mode != MODE_NONE);
    isLoad     = (read_mode != MODE_NONE);
    illegal    = (isStore && isLoad) || (write_mode > MODE_WORDRIGHT) ||
                 (read_mode > MODE_WORDRIGHT);
    accessMode = isStore ? write_mode : read_mode;
    misaligned = 1'b0;
    effK       = byteOff;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = ((accessMode == MODE_HALFWORD) && byteOff[0]) ||
                 ((accessMode == MODE_WORD) && (byteOff != 2'd0));
`else
    if (accessMode == MODE_HALFWORD) effK = {byteOff[1], 1'b0};
    if (accessMode == MODE_WORD)     effK = 2'd0;
`endif
    reqErr = illegal || outOfRange || misaligned;
  end

  // Store lane steering. swl writes the top k+1 bytes of data into bytes
  // k..0, and swr writes the low 4-k bytes of data into bytes 3..k.
  always_comb begin
    storeBe   = 4'b0000;
    storeData = data;
    case (write_mode)
      MODE_BYTE: begin
        storeBe   = 4'b0001 << effK;
        storeData = {4{data[7:0]}};
      end
      MODE_HALFWORD: begin
        storeBe   = 4'b0011 << effK;
        storeData = {2{data[15:0]}};
      end
      MODE_WORD: storeBe = 4'b1111;
      MODE_WORDLEFT: begin
        storeBe   = 4'b1111 >> (~effK);
        storeData = data >> {~effK, 3'b000};
      end
      MODE_WORDRIGHT: begin
        storeBe   = 4'b1111 << effK;
        storeData = data << {effK, 3'b000};
      end
      default: storeBe = 4'b0000;
    endcase
  end

  // Single write port: the clear sweep owns it until the unit is ready.
  always_comb begin
    memWe  = 1'b0;
    memBe  = 4'b0000;
    memIdx = wordIdx;
    memWd  = storeData;
    if (state == CLEAR) begin
      memWe  = 1'b1;
      memBe  = 4'b1111;
      memIdx = clearCount;
      memWd  = 32'd0;
    end else if (accept && isStore && !reqErr) begin
      memWe = 1'b1;
      memBe = storeBe;
    end
  end

  // RAM array with read-first ports. A fetch that collides with a store sees
  // the old word. A load one cycle after a store sees the new word because
  // the write has already landed.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (memBe[b]) mem[memIdx][8*b +: 8] <= memWd[8*b +: 8];
      end
    end
    if (accept) rdWord <= mem[wordIdx];
    if (pcRead) pcWord <= mem[pcIdx];
  end

  // Response pipeline. These registers carry what the formatter needs next
  // cycle. A failed or non-load request leaves loadModeQ at NONE, which
  // forces data_output to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      respQ     <= 1'b0;
      errQ      <= 1'b0;
      loadModeQ <= MODE_NONE;
      kQ        <= 2'd0;
      unsignedQ <= 1'b0;
      rtQ       <= 32'd0;
      pcRespQ   <= 1'b0;
    end else begin
      respQ     <= accept;
      errQ      <= accept && reqErr;
      loadModeQ <= (accept && isLoad && !reqErr) ? read_mode : MODE_NONE;
      kQ        <= effK;
      unsignedQ <= unsigned_load;
      rtQ       <= rt_data;
      pcRespQ   <= pcRead;
    end
  end

  // Load formatting. lwl places bytes k..0 at the top of the result, and
  // lwr places bytes 3..k at the bottom. The remaining bits come from rt.
  always_comb begin
    shifted     = rdWord >> {kQ, 3'b000};
    data_output = 32'd0;
    case (loadModeQ)
      MODE_BYTE:      data_output = {{24{~unsignedQ & shifted[7]}}, shifted[7:0]};
      MODE_HALFWORD:  data_output = {{16{~unsignedQ & shifted[15]}}, shifted[15:0]};
      MODE_WORD:      data_output = rdWord;
      MODE_WORDLEFT:  data_output = (rdWord << {~kQ, 3'b000}) |
                                    (rtQ & (32'h00FF_FFFF >> {kQ, 3'b000}));
      MODE_WORDRIGHT: data_output = shifted |
                                    (rtQ & ~(32'hFFFF_FFFF >> {kQ, 3'b000}));
      default:        data_output = 32'd0;
    endcase
  end

  assign resp_valid     = respQ;
  assign err            = errQ;
  assign pc_resp_valid  = pcRespQ;
  assign pc_data_output = pcRespQ ? pcWord : 32'd0;

endmodule

// File: tb/tb_mips_data_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_data_mem_unit
//
// Directed bench for mips_data_mem_unit at its default depth of 16384 words.
// A table of {request, expected response} records covers the main load/store
// behaviour. Hand-written sequences cover the reset sweep, misalignment
// handling and the fetch port.
// ---------------------------------------------------------------------------
module tb_mips_data_mem_unit;

  localparam int DEPTH = 16384;

  localparam logic [2:0] M_NONE = 3'd0;
  localparam logic [2:0] M_BYTE = 3'd1;
  localparam logic [2:0] M_HALF = 3'd2;
  localparam logic [2:0] M_WORD = 3'd3;
  localparam logic [2:0] M_WL   = 3'd4;
  localparam logic [2:0] M_WR   = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  write_mode = 3'd0;
  logic [2:0]  read_mode = 3'd0;
  logic        unsigned_load = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] data_output;
  logic        resp_valid;
  logic        err;
  logic [31:0] pc_address = 32'd0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc_data_output;
  logic        pc_resp_valid;

  int total = 0;
  int bad   = 0;

  mips_data_mem_unit #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W(32),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .write_mode(write_mode),
    .read_mode(read_mode),
    .unsigned_load(unsigned_load),
    .address(address),
    .data(data),
    .rt_data(rt_data),
    .data_output(data_output),
    .resp_valid(resp_valid),
    .err(err),
    .pc_address(pc_address),
    .pc_valid(pc_valid),
    .pc_data_output(pc_data_output),
    .pc_resp_valid(pc_resp_valid)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  wm;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic        expErr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [2:0] wm, input logic [2:0] rm,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rt,
                                 input logic expErr, input logic [31:0] expData);
    vec_t v;
    v.wm = wm; v.rm = rm; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rt = rt; v.expErr = expErr; v.expData = expData;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string label, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", label, actual, expected);
    end
  endtask

  // Present one request for exactly one edge and return #1 after that edge.
  // Back-to-back calls are therefore accepted on consecutive cycles.
  task automatic applyStimulus(input logic [2:0] wm, input logic [2:0] rm,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rt);
    write_mode    = wm;
    read_mode     = rm;
    unsigned_load = uns;
    address       = addr;
    data          = wdata;
    rt_data       = rt;
    req_valid     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic checkResponse(input string label, input logic expErr,
                               input logic [31:0] expData);
    checkOutput({label, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput({label, " err"}, {31'd0, err}, {31'd0, expErr});
    checkOutput({label, " data_output"}, data_output, expData);
  endtask

  // Count edges until req_ready rises, with a bounded budget. Also report
  // whether any response pulse appeared while the sweep was running.
  task automatic countSweep(output int n, output logic saw);
    n   = 0;
    saw = 1'b0;
    while (n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (req_ready) break;
      if (resp_valid || pc_resp_valid) saw = 1'b1;
    end
    req_valid = 1'b0;
    pc_valid  = 1'b0;
  endtask

  int          edges;
  logic        sawResp;
  logic [31:0] misWord;

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    checkOutput("reset data_output", data_output, 32'd0);
    checkOutput("reset pc_data_output", pc_data_output, 32'd0);
    checkOutput("reset pc_resp_valid", {31'd0, pc_resp_valid}, 32'd0);

    // Start a sweep, then interrupt it with a reset part way through.
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("mid-sweep req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #2;
    checkOutput("mid-sweep reset req_ready", {31'd0, req_ready}, 32'd0);

    // Restarted sweep, with requests and fetches pending that must be ignored.
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b1;
    read_mode = M_WORD;
    address   = 32'h0000_0000;
    pc_valid  = 1'b1;
    countSweep(edges, sawResp);
    checkOutput("sweep edges", edges, DEPTH + 1);
    checkOutput("sweep ignored requests", {31'd0, sawResp}, 32'd0);
    read_mode = M_NONE;

    // Directed vectors: {wm, rm, uns, addr, wdata, rt, expErr, expData}.
    addVec(M_NONE, M_WORD, 0, 32'h0000_1000, 0, 0, 0, 32'h0000_0000);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFFC, 0, 0, 0, 32'h0000_0000);
    addVec(M_WORD, M_NONE, 0, 32'h0000_FFFC, 32'h2234_5678, 0, 0, 32'h0);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFFC, 0, 0, 0, 32'h2234_5678);
    addVec(M_BYTE, M_NONE, 0, 32'h0000_FFFA, 32'h0000_00B2, 0, 0, 32'h0);
    addVec(M_BYTE, M_NONE, 0, 32'h0000_FFF8, 32'h0000_00D4, 0, 0, 32'h0);
    addVec(M_BYTE, M_NONE, 0, 32'h0000_FFFB, 32'h0000_00A1, 0, 0, 32'h0);
    addVec(M_BYTE, M_NONE, 0, 32'h0000_FFF9, 32'h0000_00C3, 0, 0, 32'h0);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0, 0, 32'hA1B2_C3D4);
    addVec(M_NONE, M_BYTE, 0, 32'h0000_FFFB, 0, 0, 0, 32'hFFFF_FFA1);
    addVec(M_NONE, M_BYTE, 1, 32'h0000_FFFB, 0, 0, 0, 32'h0000_00A1);
    addVec(M_NONE, M_HALF, 0, 32'h0000_FFF8, 0, 0, 0, 32'hFFFF_C3D4);
    addVec(M_NONE, M_HALF, 1, 32'h0000_FFFA, 0, 0, 0, 32'h0000_A1B2);
    addVec(M_WORD, M_NONE, 0, 32'h0000_FFF8, 32'h0, 0, 0, 32'h0);
    addVec(M_WL,   M_NONE, 0, 32'h0000_FFF8, 32'h1234_5678, 0, 0, 32'h0);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0, 0, 32'h0000_0012);
    addVec(M_WORD, M_NONE, 0, 32'h0000_FFF8, 32'h0, 0, 0, 32'h0);
    addVec(M_WL,   M_NONE, 0, 32'h0000_FFF9, 32'h1234_5678, 0, 0, 32'h0);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0, 0, 32'h0000_1234);
    addVec(M_WORD, M_NONE, 0, 32'h0000_FFF8, 32'h0, 0, 0, 32'h0);
    addVec(M_WL,   M_NONE, 0, 32'h0000_FFFA, 32'h1234_5678, 0, 0, 32'h0);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0, 0, 32'h0012_3456);
    addVec(M_WORD, M_NONE, 0, 32'h0000_FFF8, 32'h0000_1234, 0, 0, 32'h0);
    addVec(M_NONE, M_WL,   0, 32'h0000_FFF9, 0, 32'hAAAA_AAAA, 0, 32'h1234_AAAA);
    addVec(M_WORD, M_NONE, 0, 32'h0000_FFF8, 32'h0, 0, 0, 32'h0);
    addVec(M_WR,   M_NONE, 0, 32'h0000_FFFA, 32'h1234_5678, 0, 0, 32'h0);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0, 0, 32'h5678_0000);
    addVec(M_NONE, M_WR,   0, 32'h0000_FFFA, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_5678);
    addVec(M_NONE, M_WORD, 0, 32'h0010_0000, 0, 0, 1, 32'h0);
    addVec(M_WORD, M_NONE, 0, 32'h0010_FFF8, 32'hDEAD_BEEF, 0, 1, 32'h0);
    addVec(M_WORD, M_WORD, 0, 32'h0000_FFF8, 32'hDEAD_BEEF, 0, 1, 32'h0);
    addVec(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0, 0, 32'h5678_0000);
    addVec(M_NONE, M_NONE, 0, 32'h0000_FFF8, 0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wm, vecs[i].rm, vecs[i].uns, vecs[i].addr,
                    vecs[i].wdata, vecs[i].rt);
      checkResponse($sformatf("vec%0d", i), vecs[i].expErr, vecs[i].expData);
    end

    // resp_valid is a single-cycle pulse.
    @(posedge clk);
    #1;
    checkOutput("idle resp_valid", {31'd0, resp_valid}, 32'd0);

    // Misaligned accesses: trapped, or aligned down and completed.
    applyStimulus(M_WORD, M_NONE, 0, 32'h0000_FFF8, 32'h1122_3344, 0);
    checkResponse("mis setup", 1'b0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    misWord = 32'h1122_3344;
    applyStimulus(M_HALF, M_NONE, 0, 32'h0000_FFF9, 32'h0000_BEEF, 0);
    checkResponse("mis half store", 1'b1, 32'h0);
    applyStimulus(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0);
    checkResponse("mis readback", 1'b0, misWord);
    applyStimulus(M_NONE, M_WORD, 0, 32'h0000_FFFA, 0, 0);
    checkResponse("mis word load", 1'b1, 32'h0);
    applyStimulus(M_NONE, M_HALF, 1, 32'h0000_FFFB, 0, 0);
    checkResponse("mis half load", 1'b1, 32'h0);
`else
    misWord = 32'h1122_BEEF;
    applyStimulus(M_HALF, M_NONE, 0, 32'h0000_FFF9, 32'h0000_BEEF, 0);
    checkResponse("mis half store", 1'b0, 32'h0);
    applyStimulus(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0);
    checkResponse("mis readback", 1'b0, misWord);
    applyStimulus(M_NONE, M_WORD, 0, 32'h0000_FFFA, 0, 0);
    checkResponse("mis word load", 1'b0, misWord);
    applyStimulus(M_NONE, M_HALF, 1, 32'h0000_FFFB, 0, 0);
    checkResponse("mis half load", 1'b0, 32'h0000_1122);
`endif

    // Fetch alongside a store to the same word returns the old contents.
    pc_valid   = 1'b1;
    pc_address = 32'h0000_FFF8;
    applyStimulus(M_WORD, M_NONE, 0, 32'h0000_FFF8, 32'hCAFE_F00D, 0);
    checkResponse("fetch-store store", 1'b0, 32'h0);
    checkOutput("fetch-store pc_resp_valid", {31'd0, pc_resp_valid}, 32'd1);
    checkOutput("fetch-store pc_data_output", pc_data_output, misWord);

    // Out-of-range fetch wraps, and the low address bits are ignored.
    pc_address = 32'h0010_FFFB;
    applyStimulus(M_NONE, M_WORD, 0, 32'h0000_FFF8, 0, 0);
    checkResponse("fetch-store load", 1'b0, 32'hCAFE_F00D);
    checkOutput("wrap fetch pc_data_output", pc_data_output, 32'hCAFE_F00D);
    pc_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle pc_resp_valid", {31'd0, pc_resp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
